// File: rtl/bus_transfer_scheduler_if.sv
// bus_transfer_scheduler_if: request/grant and bus-enable bundle between requesters and the scheduler
//   req        requester -> scheduler  level request per requester
//   req_src    requester -> scheduler  5-bit bus source code per requester
//   req_dst    requester -> scheduler  5-bit destination code per requester
//   gnt        scheduler -> requester  one-hot grant pulse
//   done       scheduler -> requester  one-hot completion pulse
//   bus_out_en scheduler -> bus        one-hot source enable
//   reg_in_en  scheduler -> regfile    one-hot destination load strobe
//   busy       scheduler -> control    transfer in progress
interface bus_transfer_scheduler_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req;
    logic [5*NUM_REQ-1:0] req_src;
    logic [5*NUM_REQ-1:0] req_dst;
    logic [NUM_REQ-1:0]   gnt;
    logic [NUM_REQ-1:0]   done;
    logic [31:0]          bus_out_en;
    logic [31:0]          reg_in_en;
    logic                 busy;

    modport master (
        output req, req_src, req_dst,
        input  gnt, done, bus_out_en, reg_in_en, busy
    );

    modport slave (
        input  req, req_src, req_dst,
        output gnt, done, bus_out_en, reg_in_en, busy
    );
endinterface

// File: rtl/bus_transfer_scheduler.sv
// bus_transfer_scheduler: round-robin arbitration of register-to-register bus transfers (drive, settle, load)
//   i_clock  rising-edge clock
//   i_clear  asynchronous active-high reset
//   bus      slave modport: req/req_src/req_dst in; gnt/done/bus_out_en/reg_in_en/busy out (all registered)
module bus_transfer_scheduler #(
    parameter int NUM_REQ       = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                   i_clock,
    input  logic                   i_clear,
    bus_transfer_scheduler_if.slave bus
);
    localparam int PW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, DRIVE, LOAD} state_t;

    state_t             r_state, w_state_nxt;
    logic [3:0]         r_cnt, w_cnt_nxt;
    logic [PW-1:0]      r_ptr, r_win, w_win;
    logic [4:0]         r_dst, w_src, w_dst;
    logic [NUM_REQ-1:0] r_gnt, r_done, w_req_m;
    logic [31:0]        r_bus, r_rin;
    logic               r_busy, w_any, w_grant, w_load;
    logic [PW:0]        w_idx;

    assign w_load = (r_state == DRIVE) && (r_cnt == 4'd0);
    // the transfer completing in LOAD must not win the arbitration that overlaps it
    assign w_req_m = (r_state == LOAD) ? bus.req & ~(NUM_REQ'(1) << r_win) : bus.req;

    // descending scan so the requester closest to the pointer is written last and wins
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        w_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_idx = {1'b0, r_ptr} + (PW+1)'(i);
            if (w_idx >= (PW+1)'(NUM_REQ)) w_idx = w_idx - (PW+1)'(NUM_REQ);
            if (w_req_m[w_idx[PW-1:0]]) begin
                w_any = 1'b1;
                w_win = w_idx[PW-1:0];
            end
        end
    end

    always_comb begin
        w_src = '0;
        w_dst = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win == PW'(i)) begin
                w_src = bus.req_src[5*i +: 5];
                w_dst = bus.req_dst[5*i +: 5];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_grant     = 1'b0;
        case (r_state)
            IDLE: begin
                w_grant     = w_any;
                w_state_nxt = w_any ? DRIVE : IDLE;
            end
            DRIVE: begin
                w_state_nxt = (r_cnt == 4'd0) ? LOAD : DRIVE;
                w_cnt_nxt   = (r_cnt == 4'd0) ? r_cnt : r_cnt - 4'd1;
            end
            LOAD: begin
                w_grant     = w_any;
                w_state_nxt = w_any ? DRIVE : IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
        if (w_grant) w_cnt_nxt = 4'(SETTLE_CYCLES - 1);
    end

    always_ff @(posedge i_clock or posedge i_clear) begin
        if (i_clear) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ptr   <= '0;
            r_win   <= '0;
            r_dst   <= '0;
            r_gnt   <= '0;
            r_done  <= '0;
            r_bus   <= '0;
            r_rin   <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_gnt   <= w_grant ? NUM_REQ'(1) << w_win : '0;
            r_done  <= w_load ? NUM_REQ'(1) << r_win : '0;
            r_rin   <= w_load ? 32'd1 << r_dst : '0;
            r_bus   <= w_grant ? 32'd1 << w_src : (w_state_nxt == IDLE ? '0 : r_bus);
            r_busy  <= w_state_nxt != IDLE;
            if (w_grant) begin
                r_win <= w_win;
                r_dst <= w_dst;
                r_ptr <= (w_win == PW'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
            end
        end
    end

    assign bus.gnt        = r_gnt;
    assign bus.done       = r_done;
    assign bus.bus_out_en = r_bus;
    assign bus.reg_in_en  = r_rin;
    assign bus.busy       = r_busy;
endmodule

// File: tb/tb_bus_transfer_scheduler.sv
// tb_bus_transfer_scheduler: vector table, corner sequences and randomized reference-model check of the scheduler
module tb_bus_transfer_scheduler;
    localparam int N = 4;

    logic clk = 1'b0;
    logic clear;
    always #5 clk = ~clk;

    bus_transfer_scheduler_if #(.NUM_REQ(N)) ifa ();
    bus_transfer_scheduler_if #(.NUM_REQ(N)) ifb ();

    bus_transfer_scheduler #(.NUM_REQ(N), .SETTLE_CYCLES(1)) dut_a (
        .i_clock(clk), .i_clear(clear), .bus(ifa.slave)
    );
    bus_transfer_scheduler #(.NUM_REQ(N), .SETTLE_CYCLES(3)) dut_b (
        .i_clock(clk), .i_clear(clear), .bus(ifb.slave)
    );

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  gnt;
        logic [3:0]  done;
        logic [31:0] bus;
        logic [31:0] rin;
        logic        busy;
    } vec_t;

    int checks = 0;
    int failures = 0;
    logic [3:0] t_req;
    logic [4:0] t_src[N];
    logic [4:0] t_dst[N];
    vec_t tv[19];

    function automatic logic [31:0] oh(input int k);
        return 32'd1 << k;
    endfunction

    function automatic vec_t v(input logic [3:0] rq, g, d, input logic [31:0] b, r, input logic bz);
        vec_t x;
        x.req = rq; x.gnt = g; x.done = d; x.bus = b; x.rin = r; x.busy = bz;
        return x;
    endfunction

    task automatic drive();
        ifa.req = t_req;
        ifb.req = t_req;
        for (int i = 0; i < N; i++) begin
            ifa.req_src[5*i +: 5] = t_src[i];
            ifb.req_src[5*i +: 5] = t_src[i];
            ifa.req_dst[5*i +: 5] = t_dst[i];
            ifb.req_dst[5*i +: 5] = t_dst[i];
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_all(input int sel, input string tag, input logic [3:0] eg, ed,
                           input logic [31:0] eb, er, input logic ebz);
        logic [3:0] g, d;
        logic [31:0] b, r;
        logic bz;
        if (sel == 0) begin
            g = ifa.gnt; d = ifa.done; b = ifa.bus_out_en; r = ifa.reg_in_en; bz = ifa.busy;
        end else begin
            g = ifb.gnt; d = ifb.done; b = ifb.bus_out_en; r = ifb.reg_in_en; bz = ifb.busy;
        end
        chk({tag, ".gnt"}, 32'(g), 32'(eg));
        chk({tag, ".done"}, 32'(d), 32'(ed));
        chk({tag, ".bus_out_en"}, b, eb);
        chk({tag, ".reg_in_en"}, r, er);
        chk({tag, ".busy"}, 32'(bz), 32'(ebz));
    endtask

    task automatic do_reset();
        t_req = '0;
        drive();
        clear = 1'b1;
        @(negedge clk);
        @(negedge clk);
        clear = 1'b0;
    endtask

    // reference model: a transfer is a window of S+1 cycles numbered k=0..S after its grant
    int m_act, m_k, m_win, m_ptr;
    logic [4:0] m_src, m_dst;

    task automatic model_edge(input int s);
        int found, w, r;
        if (!m_act || m_k == s) begin
            found = 0;
            w = 0;
            for (int i = 0; i < N; i++) begin
                r = (m_ptr + i) % N;
                if (!found && t_req[r] && !(m_act && r == m_win)) begin
                    found = 1;
                    w = r;
                end
            end
            if (found) begin
                m_act = 1; m_k = 0; m_win = w;
                m_src = t_src[w]; m_dst = t_dst[w];
                m_ptr = (w + 1) % N;
            end else begin
                m_act = 0;
            end
        end else begin
            m_k++;
        end
    endtask

    initial begin
        clear = 1'b1;
        t_req = '0;
        t_src = '{5'd5, 5'd6, 5'd7, 5'd8};
        t_dst = '{5'd20, 5'd9, 5'd10, 5'd11};
        drive();
        @(negedge clk);
        @(negedge clk);
        chk_all(0, "reset_a", 4'b0, 4'b0, 32'd0, 32'd0, 1'b0);
        chk_all(1, "reset_b", 4'b0, 4'b0, 32'd0, 32'd0, 1'b0);
        clear = 1'b0;

        tv[0]  = v(4'b1111, 4'b0001, 4'b0000, oh(5), 32'd0,   1'b1);
        tv[1]  = v(4'b1111, 4'b0000, 4'b0001, oh(5), oh(20),  1'b1);
        tv[2]  = v(4'b1110, 4'b0010, 4'b0000, oh(6), 32'd0,   1'b1);
        tv[3]  = v(4'b1110, 4'b0000, 4'b0010, oh(6), oh(9),   1'b1);
        tv[4]  = v(4'b1100, 4'b0100, 4'b0000, oh(7), 32'd0,   1'b1);
        tv[5]  = v(4'b1100, 4'b0000, 4'b0100, oh(7), oh(10),  1'b1);
        tv[6]  = v(4'b1000, 4'b1000, 4'b0000, oh(8), 32'd0,   1'b1);
        tv[7]  = v(4'b1000, 4'b0000, 4'b1000, oh(8), oh(11),  1'b1);
        tv[8]  = v(4'b0000, 4'b0000, 4'b0000, 32'd0, 32'd0,   1'b0);
        tv[9]  = v(4'b0001, 4'b0001, 4'b0000, oh(5), 32'd0,   1'b1);
        tv[10] = v(4'b0001, 4'b0000, 4'b0001, oh(5), oh(20),  1'b1);
        tv[11] = v(4'b0000, 4'b0000, 4'b0000, 32'd0, 32'd0,   1'b0);
        tv[12] = v(4'b0010, 4'b0010, 4'b0000, oh(6), 32'd0,   1'b1);
        tv[13] = v(4'b0010, 4'b0000, 4'b0010, oh(6), oh(9),   1'b1);
        tv[14] = v(4'b0101, 4'b0100, 4'b0000, oh(7), 32'd0,   1'b1);
        tv[15] = v(4'b0101, 4'b0000, 4'b0100, oh(7), oh(10),  1'b1);
        tv[16] = v(4'b0001, 4'b0001, 4'b0000, oh(5), 32'd0,   1'b1);
        tv[17] = v(4'b0001, 4'b0000, 4'b0001, oh(5), oh(20),  1'b1);
        tv[18] = v(4'b0000, 4'b0000, 4'b0000, 32'd0, 32'd0,   1'b0);
        for (int i = 0; i < 19; i++) begin
            t_req = tv[i].req;
            drive();
            step();
            chk_all(0, $sformatf("tv%0d", i), tv[i].gnt, tv[i].done, tv[i].bus, tv[i].rin, tv[i].busy);
        end

        // long settle window, with source/destination changed right after the grant
        do_reset();
        t_src[0] = 5'd21;
        t_dst[0] = 5'd3;
        t_req = 4'b0001;
        drive();
        step();
        chk_all(1, "settle3_c0", 4'b0001, 4'b0000, oh(21), 32'd0, 1'b1);
        t_src[0] = 5'd2;
        t_dst[0] = 5'd7;
        drive();
        for (int k = 1; k < 4; k++) begin
            step();
            chk_all(1, $sformatf("settle3_c%0d", k), 4'b0000, (k == 3) ? 4'b0001 : 4'b0000,
                    oh(21), (k == 3) ? oh(3) : 32'd0, 1'b1);
            if (k == 3) begin
                t_req = 4'b0000;
                drive();
            end
        end
        step();
        chk_all(1, "settle3_idle", 4'b0, 4'b0, 32'd0, 32'd0, 1'b0);

        // source equal to destination
        do_reset();
        t_src = '{5'd5, 5'd13, 5'd7, 5'd8};
        t_dst = '{5'd20, 5'd13, 5'd10, 5'd11};
        t_req = 4'b0010;
        drive();
        step();
        chk_all(0, "same_drive", 4'b0010, 4'b0000, oh(13), 32'd0, 1'b1);
        step();
        chk_all(0, "same_load", 4'b0000, 4'b0010, oh(13), oh(13), 1'b1);
        t_req = 4'b0000;
        drive();
        step();
        chk_all(0, "same_idle", 4'b0, 4'b0, 32'd0, 32'd0, 1'b0);

        // clear mid-transfer: requester 1 granted while pointer favours 2; clear must restore pointer 0
        t_req = 4'b0010;
        drive();
        step();
        step();
        t_req = 4'b0000;
        drive();
        step();
        t_req = 4'b0010;
        drive();
        step();
        chk_all(0, "clr_grant", 4'b0010, 4'b0000, oh(13), 32'd0, 1'b1);
        clear = 1'b1;
        t_req = 4'b0111;
        drive();
        #1;
        chk_all(0, "clr_now", 4'b0, 4'b0, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        chk_all(0, "clr_hold", 4'b0, 4'b0, 32'd0, 32'd0, 1'b0);
        clear = 1'b0;
        step();
        chk_all(0, "clr_regrant", 4'b0001, 4'b0000, oh(5), 32'd0, 1'b1);
        step();
        chk_all(0, "clr_load0", 4'b0000, 4'b0001, oh(5), oh(20), 1'b1);

        // randomized traffic against the reference model, once per settle setting
        for (int sel = 0; sel < 2; sel++) begin
            int s;
            logic [3:0] d;
            s = (sel == 0) ? 1 : 3;
            do_reset();
            m_act = 0; m_k = 0; m_win = 0; m_ptr = 0; m_src = '0; m_dst = '0;
            for (int cyc = 0; cyc < 800; cyc++) begin
                logic [3:0] eg, ed;
                logic [31:0] eb, er;
                eg = (m_act && m_k == 0) ? 4'(1 << m_win) : 4'b0;
                ed = (m_act && m_k == s) ? 4'(1 << m_win) : 4'b0;
                eb = m_act ? oh(int'(m_src)) : 32'd0;
                er = (m_act && m_k == s) ? oh(int'(m_dst)) : 32'd0;
                chk_all(sel, $sformatf("rnd%0d_c%0d", sel, cyc), eg, ed, eb, er, m_act != 0);
                d = (sel == 0) ? ifa.done : ifb.done;
                for (int r = 0; r < N; r++) begin
                    if (d[r]) begin
                        t_req[r] = 1'b0;
                    end else if (!t_req[r]) begin
                        if ($urandom_range(2) == 0) begin
                            t_req[r] = 1'b1;
                            t_src[r] = 5'($urandom_range(31));
                            t_dst[r] = 5'($urandom_range(31));
                        end
                    end else if (m_act && m_win == r) begin
                        if ($urandom_range(5) == 0) t_req[r] = 1'b0;
                        if ($urandom_range(3) == 0) t_src[r] = 5'($urandom_range(31));
                        if ($urandom_range(3) == 0) t_dst[r] = 5'($urandom_range(31));
                    end
                end
                drive();
                model_edge(s);
                step();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
